// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: ALU operation codes and arbiter state type
package alu_share_arbiter_pkg;
  localparam int NREQ_MAX = 4;
  localparam logic [3:0] ALU_and  = 4'd0;
  localparam logic [3:0] ALU_or   = 4'd1;
  localparam logic [3:0] ALU_add  = 4'd2;
  localparam logic [3:0] ALU_sub  = 4'd3;
  localparam logic [3:0] ALU_slt  = 4'd4;
  localparam logic [3:0] ALU_sltu = 4'd5;
  localparam logic [3:0] ALU_addu = 4'd6;
  localparam logic [3:0] ALU_subu = 4'd7;
  localparam logic [3:0] ALU_xor  = 4'd8;
  localparam logic [3:0] ALU_nor  = 4'd9;
  localparam logic [3:0] ALU_sll  = 4'd10;
  localparam logic [3:0] ALU_srl  = 4'd11;
  localparam logic [3:0] ALU_sra  = 4'd12;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU; overflow reported only for signed add/sub
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [3:0]  aluctrl,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [4:0]  shift,
  output logic [31:0] result,
  output logic        overflow
);
  logic [31:0] sum, dif;
  assign sum = data1 + data2;
  assign dif = data1 - data2;
  always_comb begin
    result = '0;
    case (aluctrl)
      ALU_and:  result = data1 & data2;
      ALU_or:   result = data1 | data2;
      ALU_add:  result = sum;
      ALU_sub:  result = dif;
      ALU_slt:  result = {31'b0, $signed(data1) < $signed(data2)};
      ALU_sltu: result = {31'b0, data1 < data2};
      ALU_addu: result = sum;
      ALU_subu: result = dif;
      ALU_xor:  result = data1 ^ data2;
      ALU_nor:  result = ~(data1 | data2);
      ALU_sll:  result = data2 << shift;
      ALU_srl:  result = data2 >> shift;
      ALU_sra:  result = $signed(data2) >>> shift;
      default:  result = '0;
    endcase
  end
  assign overflow = aluctrl == ALU_add ? (data1[31] == data2[31]) && (sum[31] != data1[31]) :
                    aluctrl == ALU_sub ? (data1[31] != data2[31]) && (dif[31] != data1[31]) : 1'b0;
endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// alu_rr_pick: rotating-priority picker, first requester at or above ptr wins
module alu_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one alu with a registered, tagged response
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 4,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_aluctrl,
  input  logic [32*NREQ-1:0]   req_data1,
  input  logic [32*NREQ-1:0]   req_data2,
  input  logic [5*NREQ-1:0]    req_shift,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_overflow,
  output logic [TAGW-1:0]      rsp_tag
);
  state_t state, state_n;
  logic [IDW-1:0] ptr, idx;
  logic [NREQ-1:0] gnt;
  logic any, can_accept, fire, overflow;
  logic [31:0] result;
  alu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  alu u_alu (
    .aluctrl(req_aluctrl[idx*4 +: 4]),
    .data1(req_data1[idx*32 +: 32]),
    .data2(req_data2[idx*32 +: 32]),
    .shift(req_shift[idx*5 +: 5]),
    .result(result),
    .overflow(overflow)
  );
  // rst gates acceptance too, so no handshake can fire in a reset cycle
  assign can_accept = !rst && !flush && (state == EMPTY || rsp_ready);
  assign fire = can_accept && any;
  assign req_ready = fire ? gnt : '0;
  assign rsp_valid = state == FULL;
  always_comb state_n = fire ? FULL : (flush || rsp_ready) ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr <= '0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_overflow <= 1'b0;
      rsp_tag <= '0;
    end else begin
      state <= state_n;
      if (fire) begin
        ptr <= idx == IDW'(NREQ - 1) ? '0 : idx + 1'b1;
        rsp_id <= idx;
        rsp_result <= result;
        rsp_overflow <= overflow;
        rsp_tag <= req_tag[idx*TAGW +: TAGW];
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed steps against a round-robin/ALU scoreboard model
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;
  localparam int NREQ = 2;
  localparam int TAGW = 4;
  localparam int IDW = 1;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, rsp_ready = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [4*NREQ-1:0] req_aluctrl = '0;
  logic [32*NREQ-1:0] req_data1 = '0, req_data2 = '0;
  logic [5*NREQ-1:0] req_shift = '0;
  logic [TAGW*NREQ-1:0] req_tag = '0;
  logic rsp_valid, rsp_overflow;
  logic [IDW-1:0] rsp_id;
  logic [31:0] rsp_result;
  logic [TAGW-1:0] rsp_tag;
  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0] res;
    logic ovf;
    logic [TAGW-1:0] tag;
  } rsp_t;
  rsp_t q[$];
  int n_cmp = 0, n_err = 0, m_ptr = 0;
  bit m_full = 1'b0;
  alu_share_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluctrl(req_aluctrl), .req_data1(req_data1), .req_data2(req_data2),
    .req_shift(req_shift), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_tag(rsp_tag)
  );
  always #5 clk = ~clk;
  function automatic logic [32:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    longint s;
    case (op)
      ALU_and:  return {1'b0, a & b};
      ALU_or:   return {1'b0, a | b};
      ALU_add:  begin s = longint'($signed(a)) + longint'($signed(b)); return {s > MAXI || s < MINI, a + b}; end
      ALU_sub:  begin s = longint'($signed(a)) - longint'($signed(b)); return {s > MAXI || s < MINI, a - b}; end
      ALU_slt:  return ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
      ALU_sltu: return (a < b) ? 33'd1 : 33'd0;
      ALU_addu: return {1'b0, a + b};
      ALU_subu: return {1'b0, a - b};
      ALU_xor:  return {1'b0, a ^ b};
      ALU_nor:  return {1'b0, ~(a | b)};
      ALU_sll:  return {1'b0, b << sh};
      ALU_srl:  return {1'b0, b >> sh};
      ALU_sra:  return {1'b0, 32'($signed(b) >>> sh)};
      default:  return 33'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setr(input int i, input bit v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic [TAGW-1:0] tg);
    req_valid[i] = v;
    req_aluctrl[i*4 +: 4] = op;
    req_data1[i*32 +: 32] = a;
    req_data2[i*32 +: 32] = b;
    req_shift[i*5 +: 5] = sh;
    req_tag[i*TAGW +: TAGW] = tg;
  endtask
  // check the current cycle against the model, advance the model, then cross one clock edge
  task automatic step();
    int w, j;
    bit can;
    logic [NREQ-1:0] er;
    logic [32:0] r;
    rsp_t e;
    #1;
    can = !rst && !flush && (!m_full || rsp_ready);
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (w < 0 && req_valid[j]) w = j;
    end
    er = (can && w >= 0) ? NREQ'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full) begin
      chk("sb_depth", q.size(), 1);
      if (q.size() > 0) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_overflow", 32'(rsp_overflow), 32'(q[0].ovf));
        chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
      end
    end
    if (rst) begin
      m_full = 1'b0;
      m_ptr = 0;
      q.delete();
    end else begin
      if (m_full && (rsp_ready || flush) && q.size() > 0) void'(q.pop_front());
      if (can && w >= 0) begin
        r = model(req_aluctrl[w*4 +: 4], req_data1[w*32 +: 32], req_data2[w*32 +: 32], req_shift[w*5 +: 5]);
        e.id = IDW'(w);
        e.res = r[31:0];
        e.ovf = r[32];
        e.tag = req_tag[w*TAGW +: TAGW];
        q.push_back(e);
        m_ptr = (w + 1) % NREQ;
        m_full = 1'b1;
      end else if (flush || rsp_ready) m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  logic [3:0] t_op[8] = '{ALU_subu, ALU_sltu, ALU_slt, ALU_sub, ALU_sll, ALU_srl, ALU_nor, 4'd15};
  logic [31:0] t_a[8] = '{32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h0F0F0000, 32'h12345678};
  logic [31:0] t_b[8] = '{32'h1, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0000_0003, 32'h8000_0000, 32'h0000_00F0, 32'h9ABCDEF0};
  initial begin
    step();
    step();
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_overflow", 32'(rsp_overflow), 0);
    chk("rst_tag", 32'(rsp_tag), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    setr(0, 1, ALU_add, 32'h7FFFFFFF, 32'h1, 0, 4'h1);
    step();
    setr(0, 0, ALU_add, 0, 0, 0, 0);
    chk("t1_result", rsp_result, 32'h80000000);
    chk("t1_overflow", 32'(rsp_overflow), 1);
    step();
    setr(0, 1, ALU_add, 32'd5, 32'd6, 0, 4'h2);
    setr(1, 1, ALU_xor, 32'hFF00FF00, 32'h0FF00FF0, 0, 4'h3);
    repeat (4) step();
    setr(1, 0, ALU_xor, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      setr(0, 1, t_op[i], t_a[i], t_b[i], 5'(i + 1), 4'(i + 4));
      step();
    end
    setr(0, 0, ALU_and, 0, 0, 0, 0);
    rsp_ready = 1'b0;
    setr(1, 1, ALU_sra, 32'h0, 32'h80000000, 5'd4, 4'hA);
    repeat (3) step();
    rsp_ready = 1'b1;
    step();
    setr(1, 0, ALU_sra, 0, 0, 0, 0);
    chk("t3_result", rsp_result, 32'hF8000000);
    chk("t3_id", 32'(rsp_id), 1);
    step();
    setr(0, 1, ALU_or, 32'h00F0, 32'h0F00, 0, 4'h5);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    setr(0, 0, ALU_or, 0, 0, 0, 0);
    step();
    setr(0, 1, ALU_and, 32'hFFFF0000, 32'h0FF0F00F, 0, 4'h6);
    setr(1, 1, ALU_addu, 32'hFFFFFFFF, 32'h2, 0, 4'h7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t5_id", 32'(rsp_id), 0);
    setr(0, 0, ALU_and, 0, 0, 0, 0);
    setr(1, 0, ALU_and, 0, 0, 0, 0);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
